seven_seg_scanner: RTL and testbench
====================================

// Module: seven_seg_scanner
// PURPOSE
//  Time-multiplexed 4-digit 7-segment driver; consumes the thousands/hundreds/tens/units BCD
//  digits produced by the binary-to-BCD stage and drives shared segment lines plus per-digit anodes.
//  Digit updates are double-buffered and committed only at frame boundaries, so no frame ever
//  shows a mix of old and new digits.
// PARAMETERS
//  REFRESH_DIV    50000  clk cycles per digit slot (>= 4)
//  BLANK_CYC      16     cycles at start of each slot with all anodes off (anti-ghost); < REFRESH_DIV
//  SEG_ACTIVE_LOW 1      1: seg driven low = lit; 0: high = lit
//  AN_ACTIVE_LOW  1      1: an driven low = digit enabled
// PORTS
//  clk        in   1  system clock, all logic on rising edge
//  rst_n      in   1  synchronous reset, active low
//  load       in   1  one-cycle strobe; capture the four digit inputs into the pending buffer
//  units      in   4  BCD digit 0 (rightmost)
//  tens       in   4  BCD digit 1
//  hundreds   in   4  BCD digit 2
//  thousands  in   4  BCD digit 3 (leftmost)
//  seg        out  7  {g,f,e,d,c,b,a}, registered
//  dp         out  1  decimal point, held inactive
//  an         out  4  digit enables, an[k] = digit k, registered
//  frame_done out  1  one-cycle pulse at end of slot 3
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): slot counter=0, idx=0, shadow and pending digits=0, pend=0,
//    an all inactive, seg all unlit, dp inactive, frame_done=0. Applies mid-frame identically.
//  - Slot counter counts 0..REFRESH_DIV-1 then wraps; on wrap idx advances 0->1->2->3->0.
//  - Slot k: an[k] active when counter >= BLANK_CYC (registered: visible 1 cycle later), else all off.
//  - seg = decode(shadow digit idx); 0-9 standard patterns (act-high 3F,06,5B,4F,66,6D,7D,07,7F,6F);
//    value >9 shows dash (g only, act-high 40). SEG_ACTIVE_LOW inverts all patterns.
//  - load: pending <= inputs, pend <= 1. Repeated loads before commit: last one wins.
//  - Commit: at wrap of slot 3 (same edge frame_done pulses), if pend: shadow <= pending, pend <= 0.
//    New digits first visible in slot 0 of next frame; worst latency 4*REFRESH_DIV+1 cycles.
//  - load coinciding with commit edge: old pending commits; new values go to pending, pend stays 1.
//  - No busy/ready: load is always accepted.
// CONFIGURATION
//  SEVSEG_LZB_EN defined: leading-zero blanking on shadow digits; thousands blanked if 0; hundreds
//    if thousands=hundreds=0; tens if upper three are 0; units never blanked. A blanked slot keeps
//    its anode inactive for the full slot; timing and frame_done unchanged.
//  Not defined: all four digits always shown (0007 displays as 0007).
// STRUCTURE
//  sevseg_pkg: SEG_PAT[0:9] pattern table, SEG_DASH, SEG_OFF, DIG_IDX_W=2, NUM_DIGITS=4.
//  Sub-module bcd_to_seg: combinational 4-bit BCD -> 7-bit active-high pattern (dash for >9);
//  polarity inversion done in the scanner output register.
// TESTING  (REFRESH_DIV=8, BLANK_CYC=2, both polarities active-low)
//  1 rst_n=0 three cycles -> an=4'b1111, seg=7'h7F, dp=1, frame_done=0; stays so until load commits 0s.
//  2 load 1,2,3,4 (thou..units) -> after next frame_done: slot0 an=1110 seg=7'h19, slot3 an=0111
//    seg=7'h79; anodes off for 2 cycles at each slot start; frame_done every 32 cycles.
//  3 load 1234 then 5678 within one frame -> only 5678 committed; no frame shows mixed digits.
//  4 units=4'hC -> slot0 seg=7'h3F (dash); load coinciding with commit edge -> appears one frame later.
//  5 SEVSEG_LZB_EN: load 0,0,0,7 -> an[3:1] stay 1 all frame, slot0 seg=7'h78; load 0000 -> units
//    shows 0 (seg=7'h40). Without macro: 0007 shown on all four digits.
//  6 rst_n=0 at cycle 13 of a frame with pend=1 -> next edge all outputs at reset values, pend cleared,
//    next frame shows 0000.

Source files
------------

// File: rtl/sevseg_pkg.sv
// rtl/sevseg_pkg.sv - shared types, digit geometry and active-high segment patterns
package sevseg_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DIG_IDX_W  = 2;

    typedef logic [3:0] bcd_t;
    typedef logic [6:0] seg_t;

    // {g,f,e,d,c,b,a}, lit = 1
    localparam seg_t SEG_DASH = 7'h40;
    localparam seg_t SEG_OFF  = 7'h00;
    localparam seg_t SEG_PAT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

endpackage

// File: rtl/bcd_to_seg.sv
// rtl/bcd_to_seg.sv - combinational BCD digit to active-high segment pattern, dash for non-decimal codes
module bcd_to_seg
    import sevseg_pkg::*;
(
    input  bcd_t bcd_i,
    output seg_t seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0:    seg_o = SEG_PAT[0];
            4'd1:    seg_o = SEG_PAT[1];
            4'd2:    seg_o = SEG_PAT[2];
            4'd3:    seg_o = SEG_PAT[3];
            4'd4:    seg_o = SEG_PAT[4];
            4'd5:    seg_o = SEG_PAT[5];
            4'd6:    seg_o = SEG_PAT[6];
            4'd7:    seg_o = SEG_PAT[7];
            4'd8:    seg_o = SEG_PAT[8];
            4'd9:    seg_o = SEG_PAT[9];
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - 4-digit multiplexed 7-segment driver with frame-aligned double buffering
// Optional leading-zero blanking when SEVSEG_LZB_EN is defined.
module seven_seg_scanner
    import sevseg_pkg::*;
#(
    parameter int REFRESH_DIV    = 50000,
    parameter int BLANK_CYC      = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] units,
    input  logic [3:0] tens,
    input  logic [3:0] hundreds,
    input  logic [3:0] thousands,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       frame_done
);

    localparam int                    CNT_W     = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]      CNT_BLANK = CNT_W'(BLANK_CYC);
    localparam logic [DIG_IDX_W-1:0]  IDX_LAST  = DIG_IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF    = {NUM_DIGITS{AN_ACTIVE_LOW}};
    localparam seg_t                  SEG_UNLIT = {7{SEG_ACTIVE_LOW}};

    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [DIG_IDX_W-1:0]        idx_q, idx_d;
    bcd_t [NUM_DIGITS-1:0]       shadow_q, shadow_d;
    bcd_t [NUM_DIGITS-1:0]       pending_q, pending_d;
    logic                        pend_q, pend_d;
    seg_t                        seg_q, seg_d;
    logic [NUM_DIGITS-1:0]       an_q, an_d;
    logic                        fd_q, fd_d;

    logic                        slot_end;
    logic                        frame_end;
    logic [NUM_DIGITS-1:0]       blank_lz;
    bcd_t                        cur_digit;
    seg_t                        cur_pat;

    assign cur_digit = shadow_q[idx_q];

    bcd_to_seg u_bcd_to_seg (
        .bcd_i (cur_digit),
        .seg_o (cur_pat)
    );

`ifdef SEVSEG_LZB_EN
    // A digit is a leading zero only if every digit to its left is also zero.
    logic lz_thou, lz_hund, lz_tens;
    assign lz_thou  = (shadow_q[3] == 4'd0);
    assign lz_hund  = lz_thou && (shadow_q[2] == 4'd0);
    assign lz_tens  = lz_hund && (shadow_q[1] == 4'd0);
    assign blank_lz = {lz_thou, lz_hund, lz_tens, 1'b0};
`else
    assign blank_lz = '0;
`endif

    always_comb begin
        slot_end  = (cnt_q == CNT_LAST);
        frame_end = slot_end && (idx_q == IDX_LAST);

        cnt_d = slot_end ? '0 : cnt_q + CNT_W'(1);
        idx_d = slot_end ? idx_q + DIG_IDX_W'(1) : idx_q;

        shadow_d  = shadow_q;
        pending_d = pending_q;
        pend_d    = pend_q;
        // Commit before capture so a load on the commit edge stays pending for the next frame.
        if (frame_end && pend_q) begin
            shadow_d = pending_q;
            pend_d   = 1'b0;
        end
        if (load) begin
            pending_d = {thousands, hundreds, tens, units};
            pend_d    = 1'b1;
        end

        an_d = AN_OFF;
        if ((cnt_q >= CNT_BLANK) && !blank_lz[idx_q]) begin
            an_d = AN_OFF ^ (NUM_DIGITS'(1) << idx_q);
        end

        seg_d = (blank_lz[idx_q] ? SEG_OFF : cur_pat) ^ SEG_UNLIT;
        fd_d  = frame_end;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            shadow_q  <= '0;
            pending_q <= '0;
            pend_q    <= 1'b0;
            an_q      <= AN_OFF;
            seg_q     <= SEG_UNLIT;
            fd_q      <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            pend_q    <= pend_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            fd_q      <= fd_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = fd_q;
    assign dp         = SEG_ACTIVE_LOW;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb/tb_seven_seg_scanner.sv - directed self-checking bench for seven_seg_scanner (REFRESH_DIV=8, BLANK_CYC=2)
module tb_seven_seg_scanner;

    localparam int RD = 8;
    localparam int BC = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load = 1'b0;
    logic [3:0] units = 4'd0, tens = 4'd0, hundreds = 4'd0, thousands = 4'd0;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       frame_done;

    int errors = 0;
    int checks = 0;

    logic [3:0] an_obs  [32];
    logic [6:0] seg_obs [32];
    logic       fd_obs  [32];

    seven_seg_scanner #(
        .REFRESH_DIV    (RD),
        .BLANK_CYC      (BC),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .units      (units),
        .tens       (tens),
        .hundreds   (hundreds),
        .thousands  (thousands),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic load_digits(input logic [3:0] th, input logic [3:0] hu, input logic [3:0] te, input logic [3:0] un);
        thousands = th; hundreds = hu; tens = te; units = un;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_fd(input string tag);
        int n;
        n = 0;
        while (frame_done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL %s_fd_timeout: frame_done=%b required 1 within 40 cycles", tag, frame_done);
        end
    endtask

    // Records the 32 cycles that follow a frame_done pulse; sample j reflects slot j/8, count j%8.
    task automatic capture_frame(input string tag);
        wait_fd(tag);
        for (int j = 0; j < 32; j++) begin
            @(negedge clk);
            an_obs[j]  = an;
            seg_obs[j] = seg;
            fd_obs[j]  = frame_done;
        end
    endtask

    task automatic test_reset();
        logic [6:0] es [4];
        logic [3:0] m;
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++; if (an !== 4'b1111)  begin errors++; $display("FAIL reset_an: got %b required 1111", an); end
            checks++; if (seg !== 7'h7F)   begin errors++; $display("FAIL reset_seg: got %h required 7f", seg); end
            checks++; if (dp !== 1'b1)     begin errors++; $display("FAIL reset_dp: got %b required 1", dp); end
            checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd: got %b required 0", frame_done); end
        end
        rst_n = 1'b1;
        capture_frame("poweron");
        es = '{7'h40, 7'h40, 7'h40, 7'h40};
`ifdef SEVSEG_LZB_EN
        m = 4'b0001;
`else
        m = 4'b1111;
`endif
        for (int j = 0; j < 32; j++) begin
            logic [3:0] ea;
            ea = ((j % 8) >= BC && m[j/8]) ? ~(4'b0001 << (j/8)) : 4'hF;
            checks++; if (an_obs[j] !== ea) begin errors++; $display("FAIL poweron_an[%0d]: got %b required %b", j, an_obs[j], ea); end
            if (ea != 4'hF) begin
                checks++; if (seg_obs[j] !== es[j/8]) begin errors++; $display("FAIL poweron_seg[%0d]: got %h required %h", j, seg_obs[j], es[j/8]); end
            end
        end
    endtask

    task automatic test_load();
        logic [6:0] es [4];
        @(negedge clk);
        load_digits(4'd1, 4'd2, 4'd3, 4'd4);
        capture_frame("load");
        es = '{7'h19, 7'h30, 7'h24, 7'h79};
        for (int j = 0; j < 32; j++) begin
            logic [3:0] ea;
            ea = ((j % 8) >= BC) ? ~(4'b0001 << (j/8)) : 4'hF;
            checks++; if (an_obs[j] !== ea) begin errors++; $display("FAIL load_an[%0d]: got %b required %b", j, an_obs[j], ea); end
            if (ea != 4'hF) begin
                checks++; if (seg_obs[j] !== es[j/8]) begin errors++; $display("FAIL load_seg[%0d]: got %h required %h", j, seg_obs[j], es[j/8]); end
            end
            checks++; if (fd_obs[j] !== (j == 31)) begin errors++; $display("FAIL load_fd[%0d]: got %b required %b", j, fd_obs[j], (j == 31)); end
        end
    endtask

    task automatic test_last_wins();
        logic [6:0] es [4];
        @(negedge clk);
        load_digits(4'd1, 4'd2, 4'd3, 4'd4);
        repeat (3) @(negedge clk);
        load_digits(4'd5, 4'd6, 4'd7, 4'd8);
        capture_frame("lastwins");
        es = '{7'h00, 7'h78, 7'h02, 7'h12};
        for (int j = 0; j < 32; j++) begin
            if ((j % 8) >= BC) begin
                checks++; if (seg_obs[j] !== es[j/8]) begin errors++; $display("FAIL lastwins_seg[%0d]: got %h required %h", j, seg_obs[j], es[j/8]); end
            end
        end
    endtask

    task automatic test_dash_and_commit_edge();
        logic [6:0] es [4];
        @(negedge clk);
        load_digits(4'd9, 4'd8, 4'd7, 4'hC);
        capture_frame("dash");
        es = '{7'h3F, 7'h78, 7'h00, 7'h10};
        for (int j = 0; j < 32; j++) begin
            if ((j % 8) >= BC) begin
                checks++; if (seg_obs[j] !== es[j/8]) begin errors++; $display("FAIL dash_seg[%0d]: got %h required %h", j, seg_obs[j], es[j/8]); end
            end
        end
        // Now sitting on the frame_done sample: load 1111 early, then 2222 on the next commit edge.
        load_digits(4'd1, 4'd1, 4'd1, 4'd1);
        repeat (30) @(negedge clk);
        load_digits(4'd2, 4'd2, 4'd2, 4'd2);
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL coincide_fd: got %b required 1", frame_done); end
        capture_frame("coincide_old");
        for (int j = 0; j < 32; j++) begin
            if ((j % 8) >= BC) begin
                checks++; if (seg_obs[j] !== 7'h79) begin errors++; $display("FAIL coincide_old_seg[%0d]: got %h required 79", j, seg_obs[j]); end
            end
        end
        capture_frame("coincide_new");
        for (int j = 0; j < 32; j++) begin
            if ((j % 8) >= BC) begin
                checks++; if (seg_obs[j] !== 7'h24) begin errors++; $display("FAIL coincide_new_seg[%0d]: got %h required 24", j, seg_obs[j]); end
            end
        end
    endtask

    task automatic test_lzb();
        logic [3:0] th [3], hu [3], te [3], un [3];
        logic [3:0] m  [3];
        logic [6:0] es [3][4];
        th = '{4'd0, 4'd0, 4'd0}; hu = '{4'd0, 4'd3, 4'd0};
        te = '{4'd0, 4'd0, 4'd0}; un = '{4'd7, 4'd5, 4'd0};
        es[0] = '{7'h78, 7'h40, 7'h40, 7'h40};
        es[1] = '{7'h12, 7'h40, 7'h30, 7'h40};
        es[2] = '{7'h40, 7'h40, 7'h40, 7'h40};
`ifdef SEVSEG_LZB_EN
        m = '{4'b0001, 4'b0111, 4'b0001};
`else
        m = '{4'b1111, 4'b1111, 4'b1111};
`endif
        for (int v = 0; v < 3; v++) begin
            @(negedge clk);
            load_digits(th[v], hu[v], te[v], un[v]);
            capture_frame("lzb");
            for (int j = 0; j < 32; j++) begin
                logic [3:0] ea;
                ea = ((j % 8) >= BC && m[v][j/8]) ? ~(4'b0001 << (j/8)) : 4'hF;
                checks++; if (an_obs[j] !== ea) begin errors++; $display("FAIL lzb%0d_an[%0d]: got %b required %b", v, j, an_obs[j], ea); end
                if (ea != 4'hF) begin
                    checks++; if (seg_obs[j] !== es[v][j/8]) begin errors++; $display("FAIL lzb%0d_seg[%0d]: got %h required %h", v, j, seg_obs[j], es[v][j/8]); end
                end
                checks++; if (fd_obs[j] !== (j == 31)) begin errors++; $display("FAIL lzb%0d_fd[%0d]: got %b required %b", v, j, fd_obs[j], (j == 31)); end
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [3:0] m;
        int n;
        @(negedge clk);
        load_digits(4'd1, 4'd1, 4'd1, 4'd1);
        capture_frame("midrst_pre");
        load_digits(4'd9, 4'd9, 4'd9, 4'd9);
        repeat (12) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if (an !== 4'b1111)  begin errors++; $display("FAIL midrst_an: got %b required 1111", an); end
        checks++; if (seg !== 7'h7F)   begin errors++; $display("FAIL midrst_seg: got %h required 7f", seg); end
        checks++; if (dp !== 1'b1)     begin errors++; $display("FAIL midrst_dp: got %b required 1", dp); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL midrst_fd: got %b required 0", frame_done); end
        n = 0;
        while (frame_done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n != 32) begin errors++; $display("FAIL midrst_frame_len: got %0d required 32", n); end
        capture_frame("midrst_post");
`ifdef SEVSEG_LZB_EN
        m = 4'b0001;
`else
        m = 4'b1111;
`endif
        for (int j = 0; j < 32; j++) begin
            logic [3:0] ea;
            ea = ((j % 8) >= BC && m[j/8]) ? ~(4'b0001 << (j/8)) : 4'hF;
            checks++; if (an_obs[j] !== ea) begin errors++; $display("FAIL midrst_post_an[%0d]: got %b required %b", j, an_obs[j], ea); end
            if (ea != 4'hF) begin
                checks++; if (seg_obs[j] !== 7'h40) begin errors++; $display("FAIL midrst_post_seg[%0d]: got %h required 40", j, seg_obs[j]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_last_wins();
        test_dash_and_commit_edge();
        test_lzb();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
